// File: rtl/pal_cfg_pkg.sv
// pal_cfg_pkg: shared definitions for the PAL configuration loader.
//   - state_e    : loader FSM states
//   - num_words  : number of host words needed to cover a chain of a given length
//   - DefLen/DefW: default chain length and host word width
package pal_cfg_pkg;

   localparam int unsigned DefLen = 8;
   localparam int unsigned DefW   = 8;

   typedef enum logic [2:0] {
      StIdle,
      StWaitWord,
      StShiftLo,
      StShiftHi,
      StCheck,
      StDone
   } state_e;

   function automatic int unsigned num_words(int unsigned len, int unsigned w);
      return (len + w - 1) / w;
   endfunction

endpackage

// File: rtl/pal_cfg_ser.sv
// pal_cfg_ser: word shift register with a per-word bit index.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i and reset the index to W bits remaining
//   shift_i       : shift the word left by one bit and consume one bit
//   data_i [W]    : host word to load
//   msb_o         : bit currently at the top of the word
//   empty_o       : every bit of the loaded word has been consumed
module pal_cfg_ser #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o,
   output logic         empty_o
);

   localparam int unsigned IdxW = $clog2(W + 1);

   logic [W-1:0]    word_q, word_d;
   logic [IdxW-1:0] idx_q, idx_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (load_i) begin
         word_d = data_i;
         idx_d  = IdxW'(W);
      end else if (shift_i) begin
         word_d = word_q << 1;
         idx_d  = idx_q - IdxW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   assign msb_o   = word_q[W-1];
   assign empty_o = (idx_q == '0);

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: loads the PAL configuration shift chain from a host word stream.
// Serialises exactly LEN bits MSB-first (sr_cfg, sr_clk) and raises sr_en only after
// the last bit has been clocked in.
// Ports:
//   clk, res_n        : clock, asynchronous active-low reset
//   start             : begin a new load (ignored while busy)
//   in_data/in_valid  : host word stream, in_ready high when a word is taken
//   sr_clk/sr_cfg     : chain shift clock and serial data, both registered
//   sr_en             : chain enable, high only after a complete load
//   busy              : load in progress
//   err               : sticky parity error
// Optional feature: define PAL_CFG_LOADER_PARITY_EN to take one extra parity word after
// the payload (bit 0 = even parity over all shifted bits). Without it err is tied to 0.
module pal_cfg_loader
   import pal_cfg_pkg::*;
#(
   parameter int unsigned LEN = DefLen,
   parameter int unsigned W   = DefW
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         start,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         sr_clk,
   output logic         sr_cfg,
   output logic         sr_en,
   output logic         busy,
   output logic         err
);

   localparam int unsigned CntW = $clog2(LEN + 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
   logic            sr_clk_q, sr_clk_d;
   logic            sr_cfg_q, sr_cfg_d;
   logic            sr_en_q, sr_en_d;
   logic            ser_load, ser_shift, ser_msb, ser_empty;
`ifdef PAL_CFG_LOADER_PARITY_EN
   logic            par_q, par_d;
   logic            err_q, err_d;
`endif

   pal_cfg_ser #(
      .W (W)
   ) u_ser (
      .clk_i   (clk),
      .rst_ni  (res_n),
      .load_i  (ser_load),
      .shift_i (ser_shift),
      .data_i  (in_data),
      .msb_o   (ser_msb),
      .empty_o (ser_empty)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_clk_d  = 1'b0;
      sr_cfg_d  = sr_cfg_q;
      sr_en_d   = sr_en_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
`ifdef PAL_CFG_LOADER_PARITY_EN
      par_d     = par_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StWaitWord;
               sr_en_d   = 1'b0;
               bit_cnt_d = CntW'(LEN);
`ifdef PAL_CFG_LOADER_PARITY_EN
               par_d     = 1'b0;
               err_d     = 1'b0;
`endif
            end
         end
         StWaitWord: begin
            if (in_valid) begin
               ser_load = 1'b1;
               // The register is only written at this edge, so take the first bit
               // straight from the bus.
               sr_cfg_d = in_data[W-1];
               state_d  = StShiftLo;
            end
         end
         StShiftLo: begin
            // Bit is consumed here; sr_cfg_q already holds it and stays put through
            // the rising sr_clk that follows.
            ser_shift = 1'b1;
            bit_cnt_d = bit_cnt_q - CntW'(1);
            sr_clk_d  = 1'b1;
`ifdef PAL_CFG_LOADER_PARITY_EN
            par_d     = par_q ^ sr_cfg_q;
`endif
            state_d   = StShiftHi;
         end
         StShiftHi: begin
            // Chain count wins over word count so surplus low bits of the last
            // word are dropped.
            if (bit_cnt_q == '0) begin
`ifdef PAL_CFG_LOADER_PARITY_EN
               state_d = StCheck;
`else
               state_d = StDone;
`endif
            end else if (ser_empty) begin
               state_d = StWaitWord;
            end else begin
               sr_cfg_d = ser_msb;
               state_d  = StShiftLo;
            end
         end
`ifdef PAL_CFG_LOADER_PARITY_EN
         StCheck: begin
            if (in_valid) begin
               if (in_data[0] == par_q) begin
                  state_d = StDone;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
`endif
         StDone: begin
            sr_en_d = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         sr_clk_q  <= 1'b0;
         sr_cfg_q  <= 1'b0;
         sr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_clk_q  <= sr_clk_d;
         sr_cfg_q  <= sr_cfg_d;
         sr_en_q   <= sr_en_d;
      end
   end

`ifdef PAL_CFG_LOADER_PARITY_EN
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         par_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         par_q <= par_d;
         err_q <= err_d;
      end
   end

   assign err      = err_q;
   assign in_ready = (state_q == StWaitWord) || (state_q == StCheck);
`else
   assign err      = 1'b0;
   assign in_ready = (state_q == StWaitWord);
`endif

   assign sr_clk = sr_clk_q;
   assign sr_cfg = sr_cfg_q;
   assign sr_en  = sr_en_q;
   assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_pal_cfg_loader.sv
module tb_pal_cfg_loader;
   import pal_cfg_pkg::*;

`ifdef PAL_CFG_LOADER_PARITY_EN
   localparam int ParExtra = 1;
`else
   localparam int ParExtra = 0;
`endif

   typedef struct {
      int          sel;
      logic [7:0]  w0;
      logic [7:0]  w1;
      int          stall;
      logic [15:0] chain;
      int          edges;
      int          lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       res_n;
   logic [2:0] start, in_valid, in_ready, sr_clk, sr_cfg, sr_en, busy, err;
   logic [7:0] in_data [3];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          sel = 0;
   int          bits_left = 0;
   int          edges = 0;
   int          acc = 0;
   bit          par_acc = 1'b0;
   bit          exp_q[$];
   logic [15:0] chain_m = '0;
   logic [2:0]  prev_clk = '0;
   logic [2:0]  prev_cfg = '0;
   vec_t        vecs[5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? 8 : ((g == 1) ? 12 : 16);
      pal_cfg_loader #(
         .LEN (L),
         .W   (8)
      ) u_dut (
         .clk      (clk),
         .res_n    (res_n),
         .start    (start[g]),
         .in_data  (in_data[g]),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .sr_clk   (sr_clk[g]),
         .sr_cfg   (sr_cfg[g]),
         .sr_en    (sr_en[g]),
         .busy     (busy[g]),
         .err      (err[g])
      );
   end

   function automatic int len_of(int s);
      return (s == 0) ? 8 : ((s == 1) ? 12 : 16);
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   initial forever @(posedge clk) cyc++;

   // Chain model + scoreboard: every rising sr_clk pops one expected bit.
   initial forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         if (sr_clk[g] && !prev_clk[g]) begin
            if (g != sel) begin
               fail_now("edge_on_idle_instance");
            end else begin
               check("cfg_stable_before_edge", 32'(sr_cfg[g]), 32'(prev_cfg[g]));
               chain_m = {chain_m[14:0], sr_cfg[g]};
               edges++;
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_sr_clk_edge");
               end else begin
                  check("shifted_bit", 32'(sr_cfg[g]), 32'(exp_q.pop_front()));
               end
            end
         end
         prev_clk[g] = sr_clk[g];
         prev_cfg[g] = sr_cfg[g];
      end
   end

   task automatic begin_load(int s);
      sel       = s;
      bits_left = len_of(s);
      chain_m   = '0;
      edges     = 0;
      par_acc   = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start[sel] = 1'b1;
      @(negedge clk);
      start[sel] = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready[sel] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[sel]) fail_now("in_ready_timeout");
   endtask

   task automatic feed(logic [7:0] w, int stall, bit push, bit first);
      wait_ready();
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_sr_clk_low", 32'(sr_clk[sel]), 32'd0);
      end
      in_data[sel]  = w;
      in_valid[sel] = 1'b1;
      if (push) begin
         for (int i = 7; i >= 0; i--) begin
            if (bits_left > 0) begin
               exp_q.push_back(w[i]);
               par_acc = par_acc ^ w[i];
               bits_left--;
            end
         end
      end
      @(negedge clk);
      in_valid[sel] = 1'b0;
      if (first) acc = cyc;
   endtask

   task automatic wait_en(int want_lat);
      int n = 0;
      while (!sr_en[sel] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!sr_en[sel]) fail_now("sr_en_timeout");
      else check("sr_en_latency", 32'(cyc - acc), 32'(want_lat));
   endtask

   task automatic full_load(vec_t v, int mid_start);
      int n = 0;
      begin_load(v.sel);
      pulse_start();
      check("start_clears_sr_en", 32'(sr_en[sel]), 32'd0);
      check("busy_after_start", 32'(busy[sel]), 32'd1);
      feed(v.w0, 0, 1'b1, 1'b1);
      if (num_words(len_of(v.sel), 8) > 1) feed(v.w1, v.stall, 1'b1, 1'b0);
      if (mid_start > 0) begin
         while (edges < mid_start && n < 200) begin
            @(negedge clk);
            n++;
         end
         start[sel] = 1'b1;
         @(negedge clk);
         start[sel] = 1'b0;
         check("busy_after_ignored_start", 32'(busy[sel]), 32'd1);
      end
`ifdef PAL_CFG_LOADER_PARITY_EN
      feed({7'd0, par_acc}, 0, 1'b0, 1'b0);
`endif
      wait_en(v.lat + ParExtra);
      check("chain_value", 32'(chain_m), 32'(v.chain));
      check("edge_count", 32'(edges), 32'(v.edges));
      check("busy_when_done", 32'(busy[sel]), 32'd0);
      check("in_ready_when_done", 32'(in_ready[sel]), 32'd0);
      check("err_when_done", 32'(err[sel]), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   n;
      vecs[0] = '{sel: 0, w0: 8'hA5, w1: 8'h00, stall: 0, chain: 16'h00A5, edges: 8,  lat: 17};
      vecs[1] = '{sel: 0, w0: 8'h3C, w1: 8'h00, stall: 0, chain: 16'h003C, edges: 8,  lat: 17};
      vecs[2] = '{sel: 1, w0: 8'hAB, w1: 8'hC7, stall: 0, chain: 16'h0ABC, edges: 12, lat: 26};
      vecs[3] = '{sel: 2, w0: 8'h12, w1: 8'h34, stall: 0, chain: 16'h1234, edges: 16, lat: 34};
      vecs[4] = '{sel: 2, w0: 8'hBE, w1: 8'hEF, stall: 5, chain: 16'hBEEF, edges: 16, lat: 39};

      res_n    = 1'b0;
      start    = '0;
      in_valid = '0;
      for (int g = 0; g < 3; g++) in_data[g] = '0;
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("reset_outputs", 32'({sr_clk[g], sr_cfg[g], sr_en[g], in_ready[g], busy[g],
                                     err[g]}), 32'd0);
      end

      for (int i = 0; i < 5; i++) full_load(vecs[i], 0);

      // Reset in the middle of a load, then a clean reload.
      begin_load(0);
      pulse_start();
      feed(8'h5A, 0, 1'b1, 1'b1);
      n = 0;
      while (edges < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      res_n = 1'b0;
      #1;
      check("mid_load_reset_outputs", 32'({sr_clk[0], sr_cfg[0], sr_en[0], in_ready[0],
                                           busy[0], err[0]}), 32'd0);
      exp_q.delete();
      @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      check("no_enable_after_abort", 32'(sr_en[0]), 32'd0);
      v = '{sel: 0, w0: 8'h3C, w1: 8'h00, stall: 0, chain: 16'h003C, edges: 8, lat: 17};
      full_load(v, 0);

      // start during a load is ignored; start after completion restarts.
      v = '{sel: 0, w0: 8'h96, w1: 8'h00, stall: 0, chain: 16'h0096, edges: 8, lat: 17};
      full_load(v, 4);
      repeat (2) @(negedge clk);
      check("sr_en_holds", 32'(sr_en[0]), 32'd1);
      begin_load(0);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      check("restart_drops_sr_en", 32'(sr_en[0]), 32'd0);
      check("restart_raises_in_ready", 32'(in_ready[0]), 32'd1);
      feed(8'h00, 0, 1'b1, 1'b1);
`ifdef PAL_CFG_LOADER_PARITY_EN
      feed(8'h00, 0, 1'b0, 1'b0);
`endif
      wait_en(17 + ParExtra);
      check("restart_chain", 32'(chain_m), 32'd0);

`ifdef PAL_CFG_LOADER_PARITY_EN
      // Wrong parity word: err set, enable never asserted.
      begin_load(0);
      pulse_start();
      feed(8'hA5, 0, 1'b1, 1'b1);
      feed(8'h01, 0, 1'b0, 1'b0);
      n = 0;
      while (busy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("parity_err_set", 32'(err[0]), 32'd1);
      check("parity_err_no_en", 32'(sr_en[0]), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
